// File: rtl/md_unit.sv
// md_unit: EX-stage multiply/divide unit owning the HI/LO registers, with a busy/stall handshake.
// Optional build macro MD_MADD_EN adds madd/maddu/msub/msubu (64-bit accumulate into HI:LO).
`default_nettype none

module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] c_OP_MULT  = 4'd1;
    localparam logic [3:0] c_OP_MULTU = 4'd2;
    localparam logic [3:0] c_OP_DIV   = 4'd3;
    localparam logic [3:0] c_OP_DIVU  = 4'd4;
    localparam logic [3:0] c_OP_MTHI  = 4'd5;
    localparam logic [3:0] c_OP_MTLO  = 4'd6;
`ifdef MD_MADD_EN
    localparam logic [3:0] c_OP_MADD  = 4'd7;
    localparam logic [3:0] c_OP_MADDU = 4'd8;
    localparam logic [3:0] c_OP_MSUB  = 4'd9;
    localparam logic [3:0] c_OP_MSUBU = 4'd10;
`endif
    localparam logic [4:0] c_MULT_CNT = 5'(MULT_CYCLES);
    localparam logic [4:0] c_DIV_CNT  = 5'(DIV_CYCLES);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [4:0]  r_cnt;
    logic [4:0]  w_cnt_nxt;
    logic [3:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_is_mul;
    logic        w_is_div;
    logic        w_launch;
    logic        w_done;
    logic        w_wr;
    logic [63:0] w_res;

    always_comb begin
        w_is_mul = (op == c_OP_MULT) || (op == c_OP_MULTU);
`ifdef MD_MADD_EN
        w_is_mul = w_is_mul || (op == c_OP_MADD) || (op == c_OP_MADDU) ||
                   (op == c_OP_MSUB) || (op == c_OP_MSUBU);
`endif
        w_is_div = (op == c_OP_DIV) || (op == c_OP_DIVU);
    end

    // Next-state logic; start is honoured only in IDLE, so a request during RUN is dropped.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_launch    = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && (w_is_mul || w_is_div)) begin
                    w_launch    = 1'b1;
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = w_is_div ? c_DIV_CNT : c_MULT_CNT;
                end
            end
            S_RUN: begin
                w_cnt_nxt = r_cnt - 5'd1;
                if (r_cnt == 5'd1) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 5'd0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 5'd0;
            end
        endcase
    end

    // Products on the latched operands; the signed one is the sign-extended product truncated to 64 bits.
    logic [63:0] w_prod_u;
    logic [63:0] w_prod_s;
    assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};
    assign w_prod_s = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};

    // Signed division via magnitudes, so 0x80000000 / -1 yields 0x80000000 without overflow.
    logic        w_sdiv;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic [31:0] w_q;
    logic [31:0] w_r;
    assign w_sdiv  = (r_op == c_OP_DIV);
    assign w_mag_a = (w_sdiv && r_a[31]) ? (32'd0 - r_a) : r_a;
    assign w_mag_b = (w_sdiv && r_b[31]) ? (32'd0 - r_b) : r_b;
    assign w_uq    = (r_b == 32'd0) ? 32'd0 : (w_mag_a / w_mag_b);
    assign w_ur    = (r_b == 32'd0) ? 32'd0 : (w_mag_a % w_mag_b);
    assign w_q     = (w_sdiv && (r_a[31] ^ r_b[31])) ? (32'd0 - w_uq) : w_uq;
    assign w_r     = (w_sdiv && r_a[31]) ? (32'd0 - w_ur) : w_ur;

    always_comb begin
        w_res = {r_hi, r_lo};
        w_wr  = 1'b0;
        case (r_op)
            c_OP_MULT:  begin w_res = w_prod_s; w_wr = 1'b1; end
            c_OP_MULTU: begin w_res = w_prod_u; w_wr = 1'b1; end
            c_OP_DIV, c_OP_DIVU: begin
                w_res = {w_r, w_q};
                w_wr  = (r_b != 32'd0);
            end
`ifdef MD_MADD_EN
            // HI/LO cannot change during RUN, so they still hold the start-edge accumulator value.
            c_OP_MADD:  begin w_res = {r_hi, r_lo} + w_prod_s; w_wr = 1'b1; end
            c_OP_MADDU: begin w_res = {r_hi, r_lo} + w_prod_u; w_wr = 1'b1; end
            c_OP_MSUB:  begin w_res = {r_hi, r_lo} - w_prod_s; w_wr = 1'b1; end
            c_OP_MSUBU: begin w_res = {r_hi, r_lo} - w_prod_u; w_wr = 1'b1; end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 5'd0;
            r_op    <= 4'd0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_launch) begin
                r_op <= op;
                r_a  <= a;
                r_b  <= b;
            end
            if (w_done && w_wr) begin
                r_hi <= w_res[63:32];
                r_lo <= w_res[31:0];
            end else if ((r_state == S_IDLE) && start && (op == c_OP_MTHI)) begin
                r_hi <= a;
            end else if ((r_state == S_IDLE) && start && (op == c_OP_MTLO)) begin
                r_lo <= a;
            end
        end
    end

    assign busy     = (r_state == S_RUN);
    assign stall_md = start | busy;
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_md_unit.sv
// tb_md_unit: directed plus randomized check of md_unit against a behavioural HI/LO model.
`default_nettype none

module tb_md_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  op    = 4'd0;
    logic [31:0] a     = 32'd0;
    logic [31:0] b     = 32'd0;
    logic        busy;
    logic        stall_md;
    logic [31:0] hi;
    logic [31:0] lo;

    always #5 clk = ~clk;

    md_unit #(
        .MULT_CYCLES(MC),
        .DIV_CYCLES (DC)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .stall_md(stall_md),
        .hi      (hi),
        .lo      (lo)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: result of an op from plain 64-bit arithmetic. Returns {launches, writes, {hi,lo}}.
    function automatic logic [65:0] model_op(input logic [3:0] o, input logic [31:0] x,
                                             input logic [31:0] y, input logic [63:0] acc);
        logic [63:0] ps;
        logic [63:0] pu;
        longint      q;
        longint      r;
        logic [63:0] uq;
        logic [63:0] ur;
        ps = longint'($signed(x)) * longint'($signed(y));
        pu = 64'(x) * 64'(y);
        model_op = {2'b00, 64'd0};
        case (o)
            4'd1: model_op = {2'b11, ps};
            4'd2: model_op = {2'b11, pu};
            4'd3: begin
                if (y == 32'd0) model_op = {2'b10, acc};
                else begin
                    q = longint'($signed(x)) / longint'($signed(y));
                    r = longint'($signed(x)) % longint'($signed(y));
                    model_op = {2'b11, r[31:0], q[31:0]};
                end
            end
            4'd4: begin
                if (y == 32'd0) model_op = {2'b10, acc};
                else begin
                    uq = 64'(x) / 64'(y);
                    ur = 64'(x) % 64'(y);
                    model_op = {2'b11, ur[31:0], uq[31:0]};
                end
            end
`ifdef MD_MADD_EN
            4'd7:  model_op = {2'b11, acc + ps};
            4'd8:  model_op = {2'b11, acc + pu};
            4'd9:  model_op = {2'b11, acc - ps};
            4'd10: model_op = {2'b11, acc - pu};
`endif
            default: ;
        endcase
    endfunction

    logic [31:0] m_hi   = 32'd0;
    logic [31:0] m_lo   = 32'd0;
    int          m_left = 0;
    logic        m_wr   = 1'b0;
    logic [63:0] m_pend = 64'd0;

    always @(posedge clk or negedge reset) begin : model
        logic [65:0] res;
        if (!reset) begin
            m_hi   <= 32'd0;
            m_lo   <= 32'd0;
            m_left <= 0;
            m_wr   <= 1'b0;
            m_pend <= 64'd0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1 && m_wr) {m_hi, m_lo} <= m_pend;
        end else if (start) begin
            res = model_op(op, a, b, {m_hi, m_lo});
            if (op == 4'd5) m_hi <= a;
            else if (op == 4'd6) m_lo <= a;
            else if (res[65]) begin
                m_left <= (op == 4'd3 || op == 4'd4) ? DC : MC;
                m_wr   <= res[64];
                m_pend <= res[63:0];
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("busy",     {31'd0, busy},     {31'd0, (m_left != 0)});
            check("stall_md", {31'd0, stall_md}, {31'd0, (start || m_left != 0)});
            check("hi", hi, m_hi);
            check("lo", lo, m_lo);
        end
    end

    // Issue one op; counts busy cycles; optionally pulses a mult 2*2 in busy cycle 'inj'.
    task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                         input int inj, output int nb);
        @(posedge clk); #1;
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; op = 4'd0; a = $urandom; b = $urandom;
        nb = 0;
        for (int k = 0; k < 64; k++) begin
            if (!busy) break;
            nb++;
            if (inj != 0 && nb == inj) begin
                start = 1'b1; op = 4'd1; a = 32'd2; b = 32'd2;
            end else begin
                start = 1'b0; op = 4'd0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0; op = 4'd0;
        check("busy_timeout", {31'd0, busy}, 32'd0);
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int nb;
        logic [3:0] ro;
        repeat (3) @(posedge clk);
        #1;
        check("reset_hi",   hi, 32'd0);
        check("reset_lo",   lo, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        reset  = 1'b1;
        cmp_en = 1'b1;

        // Asynchronous reset in cycle 3 of a mult abandons it.
        issue(4'd5, 32'h55, 32'd0, 0, nb);
        check("mthi_hi", hi, 32'h55);
        @(posedge clk); #1;
        start = 1'b1; op = 4'd1; a = 32'd7; b = 32'd9;
        @(posedge clk); #1;
        start = 1'b0; op = 4'd0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 reset = 1'b0;
        #1;
        check("midrun_rst_hi",   hi, 32'd0);
        check("midrun_rst_lo",   lo, 32'd0);
        check("midrun_rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        issue(4'd6, 32'h1234, 32'd0, 0, nb);
        check("mtlo_lo", lo, 32'h1234);
        check("mtlo_nbusy", nb, 0);

        issue(4'd1, 32'hFFFF_FFFE, 32'd3, 0, nb);
        check("mult_nbusy", nb, MC);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFA);
        issue(4'd2, 32'hFFFF_FFFE, 32'd3, 0, nb);
        check("multu_hi", hi, 32'h0000_0002);
        check("multu_lo", lo, 32'hFFFF_FFFA);

        issue(4'd3, 32'hFFFF_FFF9, 32'd2, 0, nb);
        check("div_nbusy", nb, DC);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);
        issue(4'd4, 32'd7, 32'd2, 0, nb);
        check("divu_lo", lo, 32'd3);
        check("divu_hi", hi, 32'd1);

        issue(4'd5, 32'hAA, 32'd0, 0, nb);
        issue(4'd6, 32'hBB, 32'd0, 0, nb);
        issue(4'd4, 32'd5, 32'd0, 0, nb);
        check("div0_nbusy", nb, DC);
        check("div0_hi", hi, 32'hAA);
        check("div0_lo", lo, 32'hBB);

        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, nb);
        check("divovf_lo", lo, 32'h8000_0000);
        check("divovf_hi", hi, 32'd0);

        issue(4'd4, 32'd7, 32'd2, 3, nb);
        check("ignored_nbusy", nb, DC);
        check("ignored_lo", lo, 32'd3);
        check("ignored_hi", hi, 32'd1);

        issue(4'd12, 32'd9, 32'd9, 0, nb);
        check("reserved_nbusy", nb, 0);
        check("reserved_lo", lo, 32'd3);

`ifdef MD_MADD_EN
        issue(4'd5, 32'd0, 32'd0, 0, nb);
        issue(4'd6, 32'hFFFF_FFFF, 32'd0, 0, nb);
        issue(4'd8, 32'd1, 32'd1, 0, nb);
        check("maddu_nbusy", nb, MC);
        check("maddu_hi", hi, 32'd1);
        check("maddu_lo", lo, 32'd0);
        issue(4'd5, 32'd0, 32'd0, 0, nb);
        issue(4'd6, 32'd0, 32'd0, 0, nb);
        issue(4'd9, 32'd1, 32'd1, 0, nb);
        check("msub_hi", hi, 32'hFFFF_FFFF);
        check("msub_lo", lo, 32'hFFFF_FFFF);
`else
        issue(4'd7, 32'd1, 32'd1, 0, nb);
        check("madd_off_nbusy", nb, 0);
`endif

        for (int i = 0; i < 80; i++) begin
            ro = 4'($urandom_range(0, 15));
            issue(ro, rnd_operand(), rnd_operand(),
                  ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, MC)) : 0, nb);
        end

        repeat (2) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit in the EX stage, directly downstream of the decode-stage register file.
- Consumes the forwarded operands RegRData1/RegRData2 (carried through the ID/EX register) and owns the HI/LO architectural registers.
- Provides a multi-cycle busy indication so the hazard unit can stall mult/div/mfhi/mflo/mthi/mtlo in decode.
- Results are visible on hi/lo for mfhi/mflo in EX.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (and madd family when enabled); legal range 1..31.
- DIV_CYCLES, 10, busy cycles for div/divu; legal range 1..31.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request; op, a and b are valid this cycle.
- op  input  4  0=none, 1=mult, 2=multu, 3=div, 4=divu, 5=mthi, 6=mtlo, 7=madd, 8=maddu, 9=msub, 10=msubu; 11..15 reserved.
- a  input  32  rs operand (forwarded).
- b  input  32  rt operand (forwarded).
- busy  output  1  multi-cycle operation in flight.
- stall_md  output  1  combinational start OR busy, for the hazard unit.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset (reset low, async): hi=0, lo=0, busy=0, counter=0, FSM=IDLE, latched operands cleared. An in-flight operation is abandoned and no result is written.
- FSM states: IDLE, RUN.
- IDLE + start + op in {1,2,3,4,7..10} -> RUN:
  - a, b and op latched at that edge.
  - counter loaded with MULT_CYCLES for ops 1,2,7..10, or DIV_CYCLES for ops 3,4.
  - busy=1 from the next cycle.
- RUN: counter decrements each edge. On the edge where counter==1:
  - hi/lo are written, busy falls, FSM -> IDLE.
  - busy is high for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES) after the start cycle.
  - New hi/lo are visible in cycle N+1 after start.
- IDLE + start + op 5 (mthi): hi<=a at that edge, lo unchanged, busy stays 0.
- IDLE + start + op 6 (mtlo): lo<=a at that edge, hi unchanged, busy stays 0.
- Arithmetic:
  - mult: {hi,lo}=signed(a)*signed(b), 64-bit.
  - multu: unsigned 64-bit product.
  - div: lo=signed quotient truncated toward zero; hi=remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - div/divu with b==0: hi/lo unchanged; the busy sequence still runs for DIV_CYCLES.
  - div of 0x80000000 by 0xFFFFFFFF: lo=0x80000000, hi=0.
- Result computation may be combinational on the latched operands at the final edge; an iterative datapath is equally acceptable. hi/lo must not change during RUN.
- start while busy=1 is ignored; the hazard unit guarantees this cannot occur. The bench checks that state is unchanged.
- start with op 0 or 11..15: no effect.
- stall_md depends only on the start and busy inputs/state; it has no dependence on op.

Optional Feature:
- Macro MD_MADD_EN.
- Defined: ops 7..10 are implemented and use MULT_CYCLES:
  - madd: {hi,lo} += signed product.
  - maddu: {hi,lo} += unsigned product.
  - msub: {hi,lo} -= signed product.
  - msubu: {hi,lo} -= unsigned product.
  - The accumulate uses the hi/lo values at the start edge; 64-bit wrap-around with no saturation.
- Undefined: ops 7..10 are treated as reserved (no effect, busy stays 0) and the accumulate datapath is not synthesised.

Test Plan:
- Reset low mid-RUN (cycle 3 of a mult) -> hi=lo=0, busy=0 immediately; after release, start mtlo a=0x1234 -> lo=0x1234 next cycle.
- mult a=0xFFFFFFFE (-2), b=3 -> busy high cycles 1..5; cycle 6: hi=0xFFFFFFFF, lo=0xFFFFFFFA. multu with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- div a=0xFFFFFFF9 (-7), b=2 -> busy for 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu a=7, b=2 -> lo=3, hi=1.
- divu a=5, b=0 with hi=0xAA, lo=0xBB preloaded via mthi/mtlo -> busy for 10 cycles, then hi=0xAA, lo=0xBB.
- A second start during busy (mult a=2, b=2) -> ignored; final result is that of the first op; stall_md=1 throughout.
- (MD_MADD_EN) hi=0, lo=0xFFFFFFFF, then maddu a=1, b=1 -> hi=1, lo=0. msub a=1, b=1 from hi=lo=0 -> hi=lo=0xFFFFFFFF.
